// File: rtl/read_query_arbiter.sv
// read_query_arbiter
// Round-robin arbiter sharing the single read-RAM query port between
// NUM_REQ requesters. Each granted query is registered onto the RAM query
// port and followed by a tag pipeline of RAM_LAT+1 stages. When the tag
// reaches the last stage, the RAM byte is valid. The byte is then returned
// to the owning requester together with the echoed status, position and
// read number.
//
// Handshake: a requester holds req_valid and its fields stable. The query
// is accepted on the clock edge that ends a cycle in which req_ready (one-hot)
// was high. There is no back-pressure on the response side. rsp_valid is a
// one-hot strobe that consumers must qualify with !stall, because every
// register, including rsp_valid, holds its value while stall is high.
module read_query_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int READ_NUM_WIDTH = 6,
  parameter int RAM_LAT        = 3
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               stall,
  input  logic                               load_done,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*6-1:0]               req_status,
  input  logic [NUM_REQ*7-1:0]               req_position,
  input  logic [NUM_REQ*READ_NUM_WIDTH-1:0]  req_read_num,
  output logic [5:0]                         status_query,
  output logic [6:0]                         query_position,
  output logic [READ_NUM_WIDTH-1:0]          query_read_num,
  input  logic [7:0]                         new_read_query,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [7:0]                         rsp_data,
  output logic [5:0]                         rsp_status,
  output logic [6:0]                         rsp_position,
  output logic [READ_NUM_WIDTH-1:0]          rsp_read_num,
  output logic                               busy
);

  // Status code carried by an empty query slot.
  localparam logic [5:0] BUBBLE = 6'b110000;
  // Pointer width; at least one bit even for the smallest arbiter.
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Stage 0 is the issue register, stage RAM_LAT lines up with the RAM byte.
  localparam int NSTG  = RAM_LAT + 1;

  // Index arithmetic modulo NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int off);
    return PTR_W'((int'(base) + off) % NUM_REQ);
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [PTR_W-1:0]          r_ptr;

  logic                      r_tag_valid    [NSTG];
  logic [NUM_REQ-1:0]        r_tag_owner    [NSTG];
  logic [5:0]                r_tag_status   [NSTG];
  logic [6:0]                r_tag_position [NSTG];
  logic [READ_NUM_WIDTH-1:0] r_tag_read_num [NSTG];

  logic [NUM_REQ-1:0]        r_rsp_valid;
  logic [7:0]                r_rsp_data;
  logic [5:0]                r_rsp_status;
  logic [6:0]                r_rsp_position;
  logic [READ_NUM_WIDTH-1:0] r_rsp_read_num;

  // ---------------------------------------------------------------------
  // Combinational arbitration
  // ---------------------------------------------------------------------
  logic                      w_eligible;
  logic                      w_found;
  logic [PTR_W-1:0]          w_winner;
  logic [PTR_W-1:0]          w_next_ptr;
  logic [NUM_REQ-1:0]        w_grant;
  logic [5:0]                w_sel_status;
  logic [6:0]                w_sel_position;
  logic [READ_NUM_WIDTH-1:0] w_sel_read_num;
  logic                      w_busy;

  // Grants are possible only out of reset, with the RAM loaded and
  // the pipeline moving.
  assign w_eligible = reset_n & load_done & ~stall;

  // Search for the first valid requester, starting at the pointer and wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_eligible && req_valid[wrap_add(r_ptr, k)]) begin
        w_found  = 1'b1;
        w_winner = wrap_add(r_ptr, k);
      end
    end
  end

  // Turn the winner index into a one-hot grant, or zero when no requester wins.
  always_comb begin
    w_grant = '0;
    if (w_found) w_grant[w_winner] = 1'b1;
  end

  assign w_next_ptr = wrap_add(w_winner, 1);

  // Select the winner's query fields using the one-hot grant.
  always_comb begin
    w_sel_status   = '0;
    w_sel_position = '0;
    w_sel_read_num = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_status   = req_status[6*i +: 6];
        w_sel_position = req_position[7*i +: 7];
        w_sel_read_num = req_read_num[READ_NUM_WIDTH*i +: READ_NUM_WIDTH];
      end
    end
  end

  // busy is high while any tag stage holds a live query.
  always_comb begin
    w_busy = 1'b0;
    for (int s = 0; s < NSTG; s++) begin
      w_busy = w_busy | r_tag_valid[s];
    end
  end

  // ---------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------

  // Issue stage and pointer: register the winner, or a bubble when there is no grant.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ptr             <= '0;
      r_tag_valid[0]    <= 1'b0;
      r_tag_owner[0]    <= '0;
      r_tag_status[0]   <= BUBBLE;
      r_tag_position[0] <= '0;
      r_tag_read_num[0] <= '0;
    end else if (!stall) begin
      if (w_found) begin
        r_ptr             <= w_next_ptr;
        r_tag_valid[0]    <= 1'b1;
        r_tag_owner[0]    <= w_grant;
        r_tag_status[0]   <= w_sel_status;
        r_tag_position[0] <= w_sel_position;
        r_tag_read_num[0] <= w_sel_read_num;
      end else begin
        r_tag_valid[0]    <= 1'b0;
        r_tag_owner[0]    <= '0;
        r_tag_status[0]   <= BUBBLE;
        r_tag_position[0] <= '0;
        r_tag_read_num[0] <= '0;
      end
    end
  end

  // Tag stages 1..RAM_LAT: shift in step with the RAM extraction pipeline.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 1; s < NSTG; s++) begin
        r_tag_valid[s]    <= 1'b0;
        r_tag_owner[s]    <= '0;
        r_tag_status[s]   <= BUBBLE;
        r_tag_position[s] <= '0;
        r_tag_read_num[s] <= '0;
      end
    end else if (!stall) begin
      for (int s = 1; s < NSTG; s++) begin
        r_tag_valid[s]    <= r_tag_valid[s-1];
        r_tag_owner[s]    <= r_tag_owner[s-1];
        r_tag_status[s]   <= r_tag_status[s-1];
        r_tag_position[s] <= r_tag_position[s-1];
        r_tag_read_num[s] <= r_tag_read_num[s-1];
      end
    end
  end

  // Response register: capture the RAM byte for the tag that leaves the last stage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rsp_valid    <= '0;
      r_rsp_data     <= '0;
      r_rsp_status   <= BUBBLE;
      r_rsp_position <= '0;
      r_rsp_read_num <= '0;
    end else if (!stall) begin
      if (r_tag_valid[RAM_LAT]) begin
        r_rsp_valid    <= r_tag_owner[RAM_LAT];
        r_rsp_data     <= new_read_query;
        r_rsp_status   <= r_tag_status[RAM_LAT];
        r_rsp_position <= r_tag_position[RAM_LAT];
        r_rsp_read_num <= r_tag_read_num[RAM_LAT];
      end else begin
        r_rsp_valid    <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign req_ready      = w_grant;
  assign status_query   = r_tag_status[0];
  assign query_position = r_tag_position[0];
  assign query_read_num = r_tag_read_num[0];
  assign rsp_valid      = r_rsp_valid;
  assign rsp_data       = r_rsp_data;
  assign rsp_status     = r_rsp_status;
  assign rsp_position   = r_rsp_position;
  assign rsp_read_num   = r_rsp_read_num;
  assign busy           = w_busy;

endmodule

// File: tb/tb_read_query_arbiter.sv
// Bench for read_query_arbiter: a three-stage RAM model, table-driven grant
// vectors, hand-written latency, stall, load and reset sequences, and a
// response scoreboard.
module tb_read_query_arbiter;

  localparam int NR = 4;
  localparam int RW = 6;
  localparam logic [5:0] BUBBLE = 6'b110000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic            stall = 1'b0;
  logic            load_done = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [NR*6-1:0] req_status = '0;
  logic [NR*7-1:0] req_position = '0;
  logic [NR*RW-1:0] req_read_num = '0;
  logic [5:0]      status_query;
  logic [6:0]      query_position;
  logic [RW-1:0]   query_read_num;
  logic [7:0]      new_read_query;
  logic [NR-1:0]   rsp_valid;
  logic [7:0]      rsp_data;
  logic [5:0]      rsp_status;
  logic [6:0]      rsp_position;
  logic [RW-1:0]   rsp_read_num;
  logic            busy;

  read_query_arbiter #(.NUM_REQ(NR), .READ_NUM_WIDTH(RW), .RAM_LAT(3)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .load_done(load_done),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_status(req_status), .req_position(req_position), .req_read_num(req_read_num),
    .status_query(status_query), .query_position(query_position),
    .query_read_num(query_read_num), .new_read_query(new_read_query),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .rsp_position(rsp_position), .rsp_read_num(rsp_read_num), .busy(busy)
  );

  // ---------------- RAM model: 3-cycle latency, frozen by stall ----------------
  function automatic logic [7:0] ram_byte(input logic [5:0] st, input logic [6:0] pos,
                                          input logic [5:0] rn);
    return {rn, 2'b01} ^ {pos, 1'b0} ^ {st, 2'b11};
  endfunction

  logic [7:0] ram_s1 = '0, ram_s2 = '0, ram_s3 = '0;
  always @(posedge clk) begin
    if (!stall) begin
      ram_s1 <= ram_byte(status_query, query_position, query_read_num);
      ram_s2 <= ram_s1;
      ram_s3 <= ram_s2;
    end
  end
  assign new_read_query = ram_s3;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [NR-1:0] owner;
    logic [7:0]    data;
    logic [5:0]    status;
    logic [6:0]    pos;
    logic [RW-1:0] rn;
  } rsp_t;
  localparam int W = $bits(rsp_t);
  logic [W-1:0] exp_q[$];

  int checks = 0;
  int failures = 0;
  bit rand_en = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Response monitor: a strobe counts once, in a non-stalled cycle.
  logic [W-1:0] mon_exp, mon_got;
  always @(negedge clk) begin
    if (reset_n === 1'b1 && stall === 1'b0 && rsp_valid !== '0) begin
      checks++;
      mon_got = {rsp_valid, rsp_data, rsp_status, rsp_position, rsp_read_num};
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rsp actual=%0h expected=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          failures++;
          $display("FAIL rsp_match actual=%0h expected=%0h", mon_got, mon_exp);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Drive one cycle of inputs, check the grant, and push the expected response.
  task automatic step(input logic [NR-1:0] v, input logic ld, input logic st,
                      input logic [NR-1:0] exp_rdy, input string nm);
    rsp_t e;
    req_valid = v;
    load_done = ld;
    stall     = st;
    if (rand_en) begin
      for (int i = 0; i < NR; i++) begin
        req_status[6*i +: 6]     = 6'($urandom_range(0, 63));
        req_position[7*i +: 7]   = 7'($urandom_range(0, 127));
        req_read_num[RW*i +: RW] = RW'($urandom_range(0, 63));
      end
    end
    @(negedge clk);
    chk(nm, 32'(req_ready), 32'(exp_rdy));
    for (int i = 0; i < NR; i++) begin
      if (exp_rdy[i]) begin
        e.owner  = exp_rdy;
        e.status = req_status[6*i +: 6];
        e.pos    = req_position[7*i +: 7];
        e.rn     = req_read_num[RW*i +: RW];
        e.data   = ram_byte(e.status, e.pos, e.rn);
        exp_q.push_back(W'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    stall     = 1'b0;
    load_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b1, 1'b0, '0, "idle_ready");
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NR-1:0] v;
    logic          ld;
    logic          st;
    logic [NR-1:0] rdy;
  } vec_t;
  localparam int NV = 26;
  vec_t tbl [NV];

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Back-to-back round robin, all four requesting.
    tbl[0]  = '{4'b1111, 1'b1, 1'b0, 4'b0001};
    tbl[1]  = '{4'b1111, 1'b1, 1'b0, 4'b0010};
    tbl[2]  = '{4'b1111, 1'b1, 1'b0, 4'b0100};
    tbl[3]  = '{4'b1111, 1'b1, 1'b0, 4'b1000};
    tbl[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0001};
    tbl[5]  = '{4'b1111, 1'b1, 1'b0, 4'b0010};
    tbl[6]  = '{4'b1111, 1'b1, 1'b0, 4'b0100};
    tbl[7]  = '{4'b1111, 1'b1, 1'b0, 4'b1000};
    // Bring the pointer to 2, then wrap to 0 and 1, and confirm it ends at 2.
    tbl[8]  = '{4'b0011, 1'b1, 1'b0, 4'b0001};
    tbl[9]  = '{4'b0011, 1'b1, 1'b0, 4'b0010};
    tbl[10] = '{4'b0011, 1'b1, 1'b0, 4'b0001};
    tbl[11] = '{4'b0011, 1'b1, 1'b0, 4'b0010};
    tbl[12] = '{4'b1111, 1'b1, 1'b0, 4'b0100};
    tbl[13] = '{4'b0000, 1'b1, 1'b0, 4'b0000};
    tbl[14] = '{4'b1001, 1'b1, 1'b0, 4'b1000};
    tbl[15] = '{4'b1001, 1'b1, 1'b0, 4'b0001};
    // Stall blocks grants and freezes the pointer.
    tbl[16] = '{4'b1111, 1'b1, 1'b1, 4'b0000};
    tbl[17] = '{4'b1111, 1'b1, 1'b1, 4'b0000};
    tbl[18] = '{4'b1111, 1'b1, 1'b0, 4'b0010};
    // load_done low blocks grants.
    tbl[19] = '{4'b1111, 1'b0, 1'b0, 4'b0000};
    tbl[20] = '{4'b0100, 1'b1, 1'b0, 4'b0100};
    tbl[21] = '{4'b0010, 1'b1, 1'b0, 4'b0010};
    tbl[22] = '{4'b0110, 1'b1, 1'b0, 4'b0100};
    tbl[23] = '{4'b0001, 1'b1, 1'b0, 4'b0001};
    tbl[24] = '{4'b1010, 1'b1, 1'b0, 4'b0010};
    tbl[25] = '{4'b1010, 1'b1, 1'b0, 4'b1000};

    // ---- reset values (req_ready checked while reset is held) ----
    reset_n   = 1'b0;
    req_valid = 4'b1111;
    load_done = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("ready_in_reset", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_rsp_status", 32'(rsp_status), 32'(BUBBLE));
    chk("rst_rsp_position", 32'(rsp_position), 32'h0);
    chk("rst_rsp_read_num", 32'(rsp_read_num), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_status_query", 32'(status_query), 32'(BUBBLE));
    chk("rst_query_position", 32'(query_position), 32'h0);
    chk("rst_query_read_num", 32'(query_read_num), 32'h0);

    // ---- single query, fixed fields, latency ----
    do_reset();
    rand_en = 1'b0;
    req_status[5:0]   = 6'd3;
    req_position[6:0] = 7'd10;
    req_read_num[5:0] = 6'd5;
    step(4'b0001, 1'b1, 1'b0, 4'b0001, "t1_grant");
    chk("t1_query_status", 32'(status_query), 32'd3);
    chk("t1_query_position", 32'(query_position), 32'd10);
    chk("t1_query_read_num", 32'(query_read_num), 32'd5);
    step(4'b0000, 1'b1, 1'b0, 4'b0000, "t1_no_regrant");
    chk("t1_query_bubble", 32'(status_query), 32'(BUBBLE));
    step('0, 1'b1, 1'b0, '0, "t1_idle");
    step('0, 1'b1, 1'b0, '0, "t1_idle");
    chk("t1_rsp_not_early", 32'(rsp_valid), 32'h0);
    step('0, 1'b1, 1'b0, '0, "t1_idle");
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_data", 32'(rsp_data), 32'(ram_byte(6'd3, 7'd10, 6'd5)));
    chk("t1_rsp_position", 32'(rsp_position), 32'd10);
    chk("t1_rsp_read_num", 32'(rsp_read_num), 32'd5);
    step('0, 1'b1, 1'b0, '0, "t1_idle");
    chk("t1_rsp_one_pulse", 32'(rsp_valid), 32'h0);
    rand_en = 1'b1;
    chk("t1_drain", 32'(exp_q.size()), 32'h0);

    // ---- table-driven round robin / stall / load_done ----
    do_reset();
    for (int i = 0; i < NV; i++) begin
      step(tbl[i].v, tbl[i].ld, tbl[i].st, tbl[i].rdy, $sformatf("tbl_ready_%0d", i));
    end
    idle(8);
    chk("tbl_drain", 32'(exp_q.size()), 32'h0);

    // ---- stall mid-flight, and a stall overlapping the response ----
    do_reset();
    step(4'b0001, 1'b1, 1'b0, 4'b0001, "t4_grant");
    step('0, 1'b1, 1'b0, '0, "t4_idle");
    chk("t4_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 3; i++) step(4'b0001, 1'b1, 1'b1, '0, "t4_ready_in_stall");
    step('0, 1'b1, 1'b0, '0, "t4_idle");
    step('0, 1'b1, 1'b0, '0, "t4_idle");
    chk("t4_rsp_not_early", 32'(rsp_valid), 32'h0);
    step('0, 1'b1, 1'b0, '0, "t4_idle");
    chk("t4_rsp_at_7", 32'(rsp_valid), 32'h1);
    step('0, 1'b1, 1'b1, '0, "t4_stall_on_rsp");
    chk("t4_rsp_held", 32'(rsp_valid), 32'h1);
    step('0, 1'b1, 1'b0, '0, "t4_idle");
    chk("t4_rsp_one_pulse", 32'(rsp_valid), 32'h0);
    chk("t4_drain", 32'(exp_q.size()), 32'h0);

    // ---- load_done low: no grant, bubble on the query port ----
    do_reset();
    step(4'b0001, 1'b0, 1'b0, '0, "t5_no_grant");
    step(4'b0001, 1'b0, 1'b0, '0, "t5_no_grant");
    chk("t5_status_bubble", 32'(status_query), 32'(BUBBLE));
    chk("t5_position_zero", 32'(query_position), 32'h0);
    chk("t5_read_num_zero", 32'(query_read_num), 32'h0);
    chk("t5_busy_idle", 32'(busy), 32'h0);
    step(4'b0001, 1'b1, 1'b0, 4'b0001, "t5_grant_on_load");
    chk("t5_busy", 32'(busy), 32'h1);
    idle(6);
    chk("t5_drain", 32'(exp_q.size()), 32'h0);
    chk("t5_busy_drained", 32'(busy), 32'h0);

    // ---- reset with two queries in flight ----
    do_reset();
    step(4'b0011, 1'b1, 1'b0, 4'b0001, "t6_grant0");
    step(4'b0011, 1'b1, 1'b0, 4'b0010, "t6_grant1");
    chk("t6_busy", 32'(busy), 32'h1);
    reset_n = 1'b0;
    exp_q.delete();
    step(4'b0011, 1'b1, 1'b0, '0, "t6_ready_in_reset");
    reset_n = 1'b1;
    chk("t6_rsp_cleared", 32'(rsp_valid), 32'h0);
    chk("t6_busy_cleared", 32'(busy), 32'h0);
    chk("t6_query_bubble", 32'(status_query), 32'(BUBBLE));
    idle(8);
    chk("t6_busy_after", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
